// File: rtl/drp_responder.sv
// DRP responder emulating the XADC register space: status region fed by a sample
// source, read/write config region, fixed-latency drdy/do response.
module drp_responder #(
   parameter int RD_LATENCY = 4,
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 16
) (
   input  logic              CLK100MHZ,
   input  logic              reset_n,
   input  logic              den_in,
   input  logic              dwe_in,
   input  logic [ADDR_W-1:0] daddr_in,
   input  logic [DATA_W-1:0] di_in,
   output logic [DATA_W-1:0] do_out,
   output logic              drdy_out,
   input  logic              sample_valid,
   input  logic [5:0]        sample_addr,
   input  logic [DATA_W-1:0] sample_data,
   output logic              eoc_out,
   output logic [4:0]        channel_out,
   output logic              proto_err_out
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;   // read snapshot or write data
   logic [DATA_W-1:0] regs [2**ADDR_W];
   logic [ADDR_W-1:0] sample_idx;
   logic              cfg_hit;

   assign sample_idx = {{(ADDR_W-6){1'b0}}, sample_addr};
   assign cfg_hit    = (req_addr[ADDR_W-1:6] != '0);

   always_ff @(posedge CLK100MHZ or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         cnt           <= '0;
         req_we        <= 1'b0;
         req_addr      <= '0;
         req_data      <= '0;
         proto_err_out <= 1'b0;
      end else begin
         if (den_in && state != IDLE)
            proto_err_out <= 1'b1;
         case (state)
            IDLE: if (den_in) begin
               req_we   <= dwe_in;
               req_addr <= daddr_in;
               // regs still hold pre-update values here, so a same-cycle sample is not seen
               req_data <= dwe_in ? di_in : regs[daddr_in];
               cnt      <= 4'(RD_LATENCY - 1);
               state    <= (RD_LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK100MHZ or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2**ADDR_W; i++)
            regs[i] <= '0;
      end else begin
         if (sample_valid)
            regs[sample_idx] <= sample_data;
         if (state == RESP && req_we && cfg_hit)
            regs[req_addr] <= req_data;
      end
   end

   always_ff @(posedge CLK100MHZ or negedge reset_n) begin
      if (!reset_n) begin
         eoc_out     <= 1'b0;
         channel_out <= '0;
      end else begin
         eoc_out <= sample_valid;
         if (sample_valid)
            channel_out <= sample_addr[4:0];
      end
   end

   assign drdy_out = (state == RESP);
   assign do_out   = (state == RESP && !req_we) ? req_data : '0;

endmodule

// File: tb/tb_drp_responder.sv
// Bench for drp_responder: table of DRP transactions plus hand-built corner cases,
// responses matched against a queue of expected data/arrival cycles.
module tb_drp_responder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        den = 1'b0, den1 = 1'b0, dwe = 1'b0;
   logic [6:0]  daddr = '0;
   logic [15:0] di = '0;
   logic        sv = 1'b0;
   logic [5:0]  sa = '0;
   logic [15:0] sd = '0;
   logic [15:0] do0, do1;
   logic        drdy0, drdy1, eoc0, eoc1, perr0, perr1;
   logic [4:0]  ch0, ch1;

   int cyc = 0;
   int nchk = 0;
   int nfail = 0;

   typedef struct { logic [15:0] d; int due; } exp_t;
   exp_t q[$];
   exp_t q1[$];

   typedef struct { logic we; logic [6:0] addr; logic [15:0] data; logic [15:0] exp; } vec_t;
   vec_t tbl[10];

   drp_responder #(.RD_LATENCY(4)) dut (
      .CLK100MHZ(clk), .reset_n(reset_n), .den_in(den), .dwe_in(dwe), .daddr_in(daddr),
      .di_in(di), .do_out(do0), .drdy_out(drdy0), .sample_valid(sv), .sample_addr(sa),
      .sample_data(sd), .eoc_out(eoc0), .channel_out(ch0), .proto_err_out(perr0));

   drp_responder #(.RD_LATENCY(1)) dut1 (
      .CLK100MHZ(clk), .reset_n(reset_n), .den_in(den1), .dwe_in(dwe), .daddr_in(daddr),
      .di_in(di), .do_out(do1), .drdy_out(drdy1), .sample_valid(sv), .sample_addr(sa),
      .sample_data(sd), .eoc_out(eoc1), .channel_out(ch1), .proto_err_out(perr1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitors, one per DUT
   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         if (drdy0) begin
            if (q.size() == 0) chk("drdy0_unexpected", 1, 0);
            else begin
               e = q.pop_front();
               chk("do0_data", do0, e.d);
               chk("drdy0_cycle", cyc, e.due);
            end
         end else begin
            chk("do0_idle_zero", do0, 0);
            if (q.size() > 0 && cyc > q[0].due) begin
               chk("drdy0_missing", 0, 1);
               e = q.pop_front();
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         if (drdy1) begin
            if (q1.size() == 0) chk("drdy1_unexpected", 1, 0);
            else begin
               e = q1.pop_front();
               chk("do1_data", do1, e.d);
               chk("drdy1_cycle", cyc, e.due);
            end
         end else if (q1.size() > 0 && cyc > q1[0].due) begin
            chk("drdy1_missing", 0, 1);
            e = q1.pop_front();
         end
      end
   end

   // Called just after a negedge; returns at the negedge where the FSM is IDLE again.
   task automatic do_req(input logic we, input logic [6:0] a, input logic [15:0] d,
                         input logic [15:0] e);
      exp_t x;
      den = 1'b1; dwe = we; daddr = a; di = d;
      x.d = e; x.due = cyc + 4; q.push_back(x);
      @(negedge clk); den = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_req1(input logic we, input logic [6:0] a, input logic [15:0] d,
                          input logic [15:0] e);
      exp_t x;
      den1 = 1'b1; dwe = we; daddr = a; di = d;
      x.d = e; x.due = cyc + 1; q1.push_back(x);
      @(negedge clk); den1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic sample(input logic [5:0] a, input logic [15:0] d);
      sv = 1'b1; sa = a; sd = d;
   endtask

   initial begin
      exp_t x;
      tbl[0] = '{1'b0, 7'h16, 16'h0000, 16'hA5C0};
      tbl[1] = '{1'b1, 7'h41, 16'h1234, 16'h0000};
      tbl[2] = '{1'b0, 7'h41, 16'h0000, 16'h1234};
      tbl[3] = '{1'b1, 7'h16, 16'hFFFF, 16'h0000};
      tbl[4] = '{1'b0, 7'h16, 16'h0000, 16'hA5C0};
      tbl[5] = '{1'b1, 7'h7F, 16'hCAFE, 16'h0000};
      tbl[6] = '{1'b0, 7'h7F, 16'h0000, 16'hCAFE};
      tbl[7] = '{1'b0, 7'h40, 16'h0000, 16'h0000};
      tbl[8] = '{1'b0, 7'h05, 16'h0000, 16'h1110};
      tbl[9] = '{1'b0, 7'h27, 16'h0000, 16'h2220};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_drdy", drdy0, 0);
      chk("rst_do", do0, 0);
      chk("rst_eoc", eoc0, 0);
      chk("rst_chan", ch0, 0);
      chk("rst_perr", perr0, 0);
      reset_n = 1'b1;
      @(negedge clk);
      do_req(1'b0, 7'h16, 16'h0, 16'h0000);
      chk("post_rst_eoc", eoc0, 0);
      chk("post_rst_perr", perr0, 0);

      // Sample lands, eoc next cycle with channel
      sample(6'h16, 16'hA5C0);
      @(negedge clk); sv = 1'b0;
      chk("eoc_pulse", eoc0, 1);
      chk("eoc_chan", ch0, 5'h16);
      @(negedge clk);
      chk("eoc_clear", eoc0, 0);
      chk("chan_held", ch0, 5'h16);

      // Back-to-back samples, bit 5 of index dropped from channel
      sample(6'h05, 16'h1110);
      @(negedge clk); sample(6'h27, 16'h2220);
      chk("eoc_b2b_1", eoc0, 1);
      chk("chan_b2b_1", ch0, 5'h05);
      @(negedge clk); sv = 1'b0;
      chk("eoc_b2b_2", eoc0, 1);
      chk("chan_b2b_2", ch0, 5'h07);
      @(negedge clk);

      for (int i = 0; i < 10; i++)
         do_req(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].exp);

      // Same-cycle sample and den read: old value wins
      den = 1'b1; dwe = 1'b0; daddr = 7'h16; sample(6'h16, 16'h3000);
      x.d = 16'hA5C0; x.due = cyc + 4; q.push_back(x);
      @(negedge clk); den = 1'b0; sv = 1'b0;
      repeat (4) @(negedge clk);
      // Sample during WAIT must not disturb the snapshot
      den = 1'b1; daddr = 7'h16;
      x.d = 16'h3000; x.due = cyc + 4; q.push_back(x);
      @(negedge clk); den = 1'b0; sample(6'h16, 16'h4440);
      @(negedge clk); sv = 1'b0;
      repeat (3) @(negedge clk);
      do_req(1'b0, 7'h16, 16'h0, 16'h4440);

      // Protocol violation: second den two cycles into the first
      den = 1'b1; dwe = 1'b0; daddr = 7'h41;
      x.d = 16'h1234; x.due = cyc + 4; q.push_back(x);
      @(negedge clk); den = 1'b0;
      @(negedge clk);
      chk("perr_before", perr0, 0);
      den = 1'b1; daddr = 7'h7F;
      @(negedge clk); den = 1'b0;
      chk("perr_set", perr0, 1);
      repeat (2) @(negedge clk);
      do_req(1'b0, 7'h40, 16'h0, 16'h0000);
      chk("perr_sticky", perr0, 1);

      // L=1 instance: back-to-back at full rate
      do_req1(1'b0, 7'h27, 16'h0, 16'h2220);
      do_req1(1'b1, 7'h50, 16'h5555, 16'h0000);
      do_req1(1'b0, 7'h50, 16'h0, 16'h5555);
      chk("perr1_clean", perr1, 0);

      // Reset mid-transaction drops the pending write
      den = 1'b1; dwe = 1'b1; daddr = 7'h42; di = 16'hBEEF;
      @(negedge clk); den = 1'b0;
      @(negedge clk); reset_n = 1'b0;
      @(negedge clk);
      chk("midrst_drdy", drdy0, 0);
      chk("midrst_perr", perr0, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      do_req(1'b0, 7'h42, 16'h0, 16'h0000);
      do_req(1'b0, 7'h41, 16'h0, 16'h0000);
      do_req1(1'b0, 7'h50, 16'h0, 16'h0000);

      repeat (3) @(negedge clk);
      chk("sb0_drained", q.size(), 0);
      chk("sb1_drained", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/drp_responder.md
Name: drp_responder

Overview:
- Responder end of the XADC-style DRP (Dynamic Reconfiguration Port).
- Serves den/dwe/daddr/di requests from a DRP initiator with a fixed-latency drdy/do response. It emulates the XADC register space: a read-only status region fed from an external sample source, and a read/write config region.
- Generates eoc/channel pulses when a new sample lands, so a DRP consumer can run against it without the hard XADC.
- Used as a synthesizable stand-in for simulation and board bring-up.

Parameters:
- RD_LATENCY, 4, cycles from the den cycle to the drdy cycle; legal range 1..15.
- ADDR_W, 7, DRP address width; register space is 2^ADDR_W words.
- DATA_W, 16, DRP data width.

Ports:
- CLK100MHZ  in  1  sole clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- den_in  in  1  request strobe, one-cycle pulse.
- dwe_in  in  1  write enable, sampled only with den_in.
- daddr_in  in  ADDR_W  request address, sampled with den_in.
- di_in  in  DATA_W  write data, sampled with den_in.
- do_out  out  DATA_W  read data; valid only while drdy_out=1, otherwise 0.
- drdy_out  out  1  one-cycle response strobe, for reads and writes.
- sample_valid  in  1  one-cycle strobe: load sample_data into the status register.
- sample_addr  in  6  status register index 0x00..0x3F.
- sample_data  in  DATA_W  new status value, left-justified 12-bit sample.
- eoc_out  out  1  one-cycle pulse, the cycle after a status register updates.
- channel_out  out  5  sample_addr[4:0] of the last update; held between pulses.
- proto_err_out  out  1  sticky flag: den_in seen while a transaction is pending.

Behaviour:
- Reset (reset_n=0, async):
  - All outputs are 0.
  - All 2^ADDR_W registers are 0.
  - FSM goes to IDLE and the latency counter clears.
  - A pending transaction is dropped: no drdy after release, and a pending write is not committed.
- Register map:
  - Addresses 0x00..0x3F form the status region. DRP writes to it are discarded, but drdy is still returned.
  - Addresses 0x40..(2^ADDR_W-1) form the config region and are DRP read/write.
- FSM states: IDLE, WAIT, RESP.
  - IDLE + den_in=1: capture the request.
    - Read: snapshot the register value at daddr_in this cycle.
    - Write: capture di_in.
    - Load counter = RD_LATENCY-1, then go to WAIT (or to RESP directly if RD_LATENCY=1).
  - WAIT: decrement the counter each cycle; at 0 go to RESP on the next edge.
  - RESP: drdy_out=1 for exactly one cycle, then return to IDLE.
    - Read: do_out = snapshot.
    - Write: do_out = 0, and the config write commits on this edge.
- Latency: den at cycle N gives drdy at cycle N+RD_LATENCY. Back-to-back throughput is one transaction per RD_LATENCY+1 cycles (next den accepted no earlier than the cycle after RESP).
- Protocol violation: den_in=1 in WAIT or RESP.
  - The request is ignored and proto_err_out is set.
  - proto_err_out clears only on reset.
  - The in-flight transaction completes unaffected.
- Sample path, independent of the FSM:
  - sample_valid writes status[sample_addr] on that edge.
  - eoc_out=1 on the next cycle, with channel_out updated in the same cycle.
  - Back-to-back sample_valid gives back-to-back eoc pulses.
- Simultaneous events:
  - sample_valid in the same cycle as a den read of that address: the read returns the old value (snapshot taken before the update).
  - A sample update during WAIT does not alter the captured snapshot.
  - Writes never target the status region, so no write/sample conflict exists.
- Loopback (eoc_out wired to den_in): every eoc triggers a read. With sample period ≥ RD_LATENCY+1 there are no protocol errors.
- Width rules:
  - daddr_in is used in full (no aliasing).
  - sample_addr is zero-extended to ADDR_W.

Test Plan:
- Reset value check: hold reset_n=0, then release; read 0x16 → drdy exactly 4 cycles after den, do_out=0x0000, eoc_out=0, proto_err_out=0.
- Sample then read: sample_valid, addr=0x16, data=0xA5C0 → eoc_out pulse next cycle with channel_out=0x16; den read 0x16 → drdy at +4 with do_out=0xA5C0, do_out=0 on all other cycles.
- Config write/readback plus status write discard:
  - Write 0x41=0x1234, read 0x41 → 0x1234.
  - Write 0x16=0xFFFF, read 0x16 → previous 0xA5C0.
  - Both writes still return a drdy pulse.
- Protocol error: den at cycle 0, second den at cycle 2 → single drdy at cycle 4 carrying the first request's data; proto_err_out=1 from cycle 3 and stays high.
- Same-cycle collision: sample_valid (0x16, 0x3000) plus den read of 0x16 in the same cycle → do_out = old value; a subsequent read → 0x3000.
- Reset mid-transaction: write request to 0x42=0xBEEF, assert reset_n=0 at cycle 2 → no drdy, 0x42 reads 0x0000 after release. Repeat the latency check with RD_LATENCY=1 → drdy on the cycle after den.
